vga_frame_reader: RTL and testbench

Downstream consumer of the 640x480 frame RAM filled by the copy controller. Generates standard 640x480@60 Hz VGA timing from a 25 MHz pixel clock. Streams the frame RAM in raster order through a fixed two-stage read pipeline and drives 8-bit grayscale to the R/G/B DAC inputs with aligned sync and blank signals. Display is gated by `enable`, which is tied to the copy controller's `done` flag and takes effect only on frame boundaries.

---
 rtl/vga_frame_reader_if.sv | 27 ++
 rtl/vga_frame_reader.sv | 126 ++++++++++++
 tb/tb_vga_frame_reader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_reader_if.sv
// Bundle between the VGA frame reader, its frame RAM read port and the DAC/sync pins.
// The reader drives the address and video pins; the RAM/display side drives enable and read data.
interface vga_frame_reader_if;
    logic        enable;
    logic [18:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic        frame_start;

    modport master (
        input  enable, ram_rd_data,
        output ram_rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs,
               vga_blank_n, vga_sync_n, frame_start
    );

    modport slave (
        output enable, ram_rd_data,
        input  ram_rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs,
               vga_blank_n, vga_sync_n, frame_start
    );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA timing generator that streams the frame RAM in raster order through a two-stage
// read pipeline, with syncs and blank delayed to line up with the grayscale pixels.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_frame_reader_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Stage 0: raster position, read address and per-frame display latch
    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic [18:0]    r_addr_cnt;
    logic           r_display_on;

    // Stage 1: qualifiers travelling alongside the RAM read
    logic           r_active_d1;
    logic           r_hs_d1;
    logic           r_vs_d1;
    logic           r_display_on_d1;

    // Stage 2: output registers
    logic [7:0]     r_pix;
    logic           r_hs;
    logic           r_vs;
    logic           r_blank_n;

    logic w_h_last;
    logic w_frame_end;
    logic w_origin;
    logic w_active;
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_display_now;

    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_frame_end = w_h_last && (r_v_cnt == V_LAST);
    assign w_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_raw    = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
    assign w_vs_raw    = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
    // The pixel at (0,0) already belongs to the new frame, so it uses the value being latched.
    assign w_display_now = w_origin ? bus.enable : r_display_on;

    // NOTE: every register below uses non-blocking assignment so all stages update from
    // the same pre-edge values; blocking here would collapse the pipeline stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_addr_cnt   <= '0;
            r_display_on <= 1'b0;
        end else begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end

            if (w_frame_end) begin
                r_addr_cnt <= '0;
            end else if (w_active) begin
                r_addr_cnt <= r_addr_cnt + 1'b1;
            end

            if (w_origin) begin
                r_display_on <= bus.enable;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_d1     <= 1'b0;
            r_hs_d1         <= 1'b1;
            r_vs_d1         <= 1'b1;
            r_display_on_d1 <= 1'b0;
            r_pix           <= '0;
            r_hs            <= 1'b1;
            r_vs            <= 1'b1;
            r_blank_n       <= 1'b0;
        end else begin
            r_active_d1     <= w_active;
            r_hs_d1         <= w_hs_raw;
            r_vs_d1         <= w_vs_raw;
            r_display_on_d1 <= w_display_now;
            r_pix           <= (r_active_d1 && r_display_on_d1) ? bus.ram_rd_data : 8'h00;
            r_hs            <= r_hs_d1;
            r_vs            <= r_vs_d1;
            r_blank_n       <= r_active_d1;
        end
    end

    assign bus.ram_rd_addr = r_addr_cnt;
    assign bus.vga_r       = r_pix;
    assign bus.vga_g       = r_pix;
    assign bus.vga_b       = r_pix;
    assign bus.vga_hs      = r_hs;
    assign bus.vga_vs      = r_vs;
    assign bus.vga_blank_n = r_blank_n;
    assign bus.vga_sync_n  = 1'b0;
    // Gated by reset so the pulse is held off while the counters sit at (0,0) in reset.
    assign bus.frame_start = w_origin && rst_n;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a full-size instance for line-level timing and a reduced-geometry
// instance for frame-level behaviour, both checked every cycle against a raster-arithmetic model.
module tb_vga_frame_reader;
    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
    } geom_t;

    localparam geom_t G_FULL  = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33};
    localparam geom_t G_SMALL = '{ha:16,  hfp:4,  hs:8,  hbp:4,  va:16,  vfp:2,  vs:2, vbp:3};
    localparam int FULL_FRAME  = 800 * 525;
    localparam int SMALL_FRAME = 32 * 23;
    localparam logic [63:0] RESET_VEC = {16'h0, 19'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk;
    logic rst_n;

    vga_frame_reader_if if_full ();
    vga_frame_reader_if if_small ();

    vga_frame_reader dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_full)
    );

    vga_frame_reader #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (16), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_small)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Frame RAM with one-cycle synchronous read; contents are the low address byte.
    initial begin
        if_full.ram_rd_data  = 8'h00;
        if_small.ram_rd_data = 8'h00;
    end
    always @(posedge clk) begin
        if_full.ram_rd_data  <= if_full.ram_rd_addr[7:0];
        if_small.ram_rd_data <= if_small.ram_rd_addr[7:0];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;
    int phase    = 0;
    bit fen_full  [0:7];
    bit fen_small [0:7];
    int cnt_blank_full  = 0;
    int cnt_hs_low_full = 0;
    int cnt_vs_low_small = 0;
    int fs_prev_t = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s phase=%0d t=%0d actual=%h required=%h", name, phase, t, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Expected outputs at cycle t after reset release, from raster position arithmetic.
    function automatic logic [63:0] expect_out(input geom_t g, input int tc, input bit en);
        int ht, vt, h, v, p, ah, av;
        logic [18:0] addr;
        logic [7:0]  pix;
        logic hs, vs, blank, fs;
        ht = g.ha + g.hfp + g.hs + g.hbp;
        vt = g.va + g.vfp + g.vs + g.vbp;
        h  = tc % ht;
        v  = (tc / ht) % vt;
        if (v >= g.va) addr = 19'(g.ha * g.va);
        else           addr = 19'(v * g.ha + ((h < g.ha) ? h : g.ha));
        fs    = (h == 0) && (v == 0);
        pix   = 8'h00;
        hs    = 1'b1;
        vs    = 1'b1;
        blank = 1'b0;
        if (tc >= 2) begin
            p     = tc - 2;
            ah    = p % ht;
            av    = (p / ht) % vt;
            blank = (ah < g.ha) && (av < g.va);
            hs    = !((ah >= g.ha + g.hfp) && (ah < g.ha + g.hfp + g.hs));
            vs    = !((av >= g.va + g.vfp) && (av < g.va + g.vfp + g.vs));
            if (blank && en) pix = 8'((av * g.ha + ah) % 256);
        end
        return {16'h0, addr, pix, pix, pix, hs, vs, blank, 1'b0, fs};
    endfunction

    function automatic logic [63:0] act_full();
        return {16'h0, if_full.ram_rd_addr, if_full.vga_r, if_full.vga_g, if_full.vga_b,
                if_full.vga_hs, if_full.vga_vs, if_full.vga_blank_n, if_full.vga_sync_n,
                if_full.frame_start};
    endfunction

    function automatic logic [63:0] act_small();
        return {16'h0, if_small.ram_rd_addr, if_small.vga_r, if_small.vga_g, if_small.vga_b,
                if_small.vga_hs, if_small.vga_vs, if_small.vga_blank_n, if_small.vga_sync_n,
                if_small.frame_start};
    endfunction

    task automatic compare_all();
        bit ef, es;
        ef = (t >= 2) ? fen_full[(t - 2) / FULL_FRAME] : 1'b0;
        es = (t >= 2) ? fen_small[(t - 2) / SMALL_FRAME] : 1'b0;
        check("full_cycle", act_full(), expect_out(G_FULL, t, ef));
        check("small_cycle", act_small(), expect_out(G_SMALL, t, es));
    endtask

    task automatic capture();
        if (t % FULL_FRAME == 0)  fen_full[t / FULL_FRAME]   = if_full.enable;
        if (t % SMALL_FRAME == 0) fen_small[t / SMALL_FRAME] = if_small.enable;
    endtask

    // Hand-computed expectations that pin the model to known points.
    task automatic literals();
        if (phase == 0) begin
            if (t == 2)    check("full_px00_rgb", if_full.vga_r, 8'h00);
            if (t == 2)    check("full_px00_blank_n", if_full.vga_blank_n, 1'b1);
            if (t == 807)  check("full_px5_1_rgb", {if_full.vga_r, if_full.vga_g, if_full.vga_b}, 24'h858585);
            if (t == 657)  check("full_hs_before_fall", if_full.vga_hs, 1'b1);
            if (t == 658)  check("full_hs_fall", if_full.vga_hs, 1'b0);
            if (t == 753)  check("full_hs_last_low", if_full.vga_hs, 1'b0);
            if (t == 754)  check("full_hs_rise", if_full.vga_hs, 1'b1);
            if (t >= 802 && t <= 1601) begin
                cnt_blank_full  += int'(if_full.vga_blank_n);
                cnt_hs_low_full += int'(!if_full.vga_hs);
            end
            if (t == 1601) check("full_blank_n_per_line", cnt_blank_full, 640);
            if (t == 1601) check("full_hs_low_per_line", cnt_hs_low_full, 96);
            if (t >= 2 && t <= 737) cnt_vs_low_small += int'(!if_small.vga_vs);
            if (t == 737)  check("small_vs_low_per_frame", cnt_vs_low_small, 64);
            if (t == 577)  check("small_vs_before_fall", if_small.vga_vs, 1'b1);
            if (t == 578)  check("small_vs_fall", if_small.vga_vs, 1'b0);
            if (t == 195)  check("small_f0_gated_black", if_small.vga_r, 8'h00);
            if (t == 739)  check("small_f1_px1_0", if_small.vga_r, 8'h01);
            if (t == 1231) check("small_last_addr", if_small.ram_rd_addr, 19'd255);
            if (t == 1232) check("small_addr_hold", if_small.ram_rd_addr, 19'd256);
            if (t == 1233) check("small_last_px", if_small.vga_b, 8'hFF);
            if (t == 1471) check("small_addr_frame_end", if_small.ram_rd_addr, 19'd256);
            if (t == 1472) check("small_addr_wrap", if_small.ram_rd_addr, 19'd0);
            if (t == 1475) check("small_f2_same_cycle_enable", if_small.vga_r, 8'h01);
            if (if_small.frame_start && t > 0) begin
                check("small_frame_period", t - fs_prev_t, SMALL_FRAME);
                fs_prev_t = t;
            end
        end else begin
            if (t == 0) check("restart_addr0", if_small.ram_rd_addr, 19'd0);
            if (t == 5) check("restart_addr5", if_small.ram_rd_addr, 19'd5);
            if (t == 3) check("restart_px1", if_small.vga_r, 8'h01);
        end
    endtask

    task automatic drive();
        if (phase == 0) begin
            if (t == 5 * 32)               if_small.enable = 1'b1;
            if (t == SMALL_FRAME + 8 * 32) if_small.enable = 1'b0;
            if (t == 2 * SMALL_FRAME)      if_small.enable = 1'b1;
        end
    endtask

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t++;
            compare_all();
            literals();
            drive();
            capture();
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        #1;
        compare_all();
        literals();
        drive();
        capture();
        if (phase == 0) fs_prev_t = 0;
    endtask

    initial begin
        rst_n           = 1'b0;
        if_full.enable  = 1'b1;
        if_small.enable = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_full_outputs", act_full(), RESET_VEC);
        check("reset_small_outputs", act_small(), RESET_VEC);

        release_reset();
        step_cycles(2 * SMALL_FRAME + 5 * 32 + 10);

        // Mid-frame reset: small instance sits at h=10, v=5 of frame 2 here.
        rst_n = 1'b0;
        #1;
        check("midreset_full_outputs", act_full(), RESET_VEC);
        check("midreset_small_outputs", act_small(), RESET_VEC);
        repeat (3) @(negedge clk);
        check("midreset_hold_small", act_small(), RESET_VEC);

        phase = 1;
        release_reset();
        step_cycles(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
